// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between the CPU (port 0) and the program
//   loader / debug master (port 1). Each transaction runs through
//   IDLE -> ISSUE -> WAIT -> DONE. The memory controls are driven in ISSUE.
//   Read data is captured after MEM_LAT cycles, and a one-cycle ack is
//   returned in DONE.
//
//   Arbitration:
//     Round-robin by default.
//     Define ARB_CPU_PRIO_EN for fixed priority, where port 0 always wins.
//
// Parameters:
//   ADDR_W   memory word-address width
//   DATA_W   data width
//   MEM_LAT  memory read latency in cycles (>= 1)
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_req0/i_we0/i_addr0/i_wdata0    port 0 request (held until o_ack0)
//   o_ack0                           port 0 completion pulse
//   i_req1/i_we1/i_addr1/i_wdata1    port 1 request (held until o_ack1)
//   o_ack1                           port 1 completion pulse
//   o_rdata                          captured read data, held until next read
//   o_mem_addr/o_mem_wdata/o_mem_we  memory-side address/data/write-enable
//   i_mem_rdata                      memory read data
//   o_busy                           high whenever not IDLE
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    output logic              o_ack0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                port_q,  port_d;
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                grant;

`ifdef ARB_CPU_PRIO_EN
    // Port 1 only wins when the CPU is not requesting.
    assign grant = ~i_req0;
`else
    logic prio_q, prio_d;

    // The pointer only matters on a tie; a lone requester always wins.
    assign grant = (i_req0 & i_req1) ? prio_q : i_req1;
`endif

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
`ifndef ARB_CPU_PRIO_EN
        prio_d  = prio_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req0 | i_req1) begin
                    port_d  = grant;
                    we_d    = grant ? i_we1    : i_we0;
                    addr_d  = grant ? i_addr1  : i_addr0;
                    wdata_d = grant ? i_wdata1 : i_wdata0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = i_mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
`ifndef ARB_CPU_PRIO_EN
                prio_d  = ~port_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
`ifndef ARB_CPU_PRIO_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
`ifndef ARB_CPU_PRIO_EN
            prio_q  <= prio_d;
`endif
        end
    end

    // Outputs are decoded from registers only; no request input reaches them.
    // The latched address stays on the memory bus from ISSUE through WAIT.
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_we    = (state_q == S_ISSUE) & we_q;
    assign o_ack0      = (state_q == S_DONE) & ~port_q;
    assign o_ack1      = (state_q == S_DONE) &  port_q;
    assign o_rdata     = rdata_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;
`ifdef ARB_CPU_PRIO_EN
    localparam bit CPU_PRIO = 1'b1;
`else
    localparam bit CPU_PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: MEM_LAT = 1, both ports exercised
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, mwe, busy;
    logic [DW-1:0] rdata, mwdata, mrdata;
    logic [AW-1:0] maddr;

    // DUT B: MEM_LAT = 3, port 0 only
    logic          reqb;
    logic [AW-1:0] addrb;
    logic          ackb, ack1b, mweb, busyb;
    logic [DW-1:0] rdatab, mwdatab, mrdatab;
    logic [AW-1:0] maddrb;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0), .o_ack0(ack0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .o_ack1(ack1),
        .o_rdata(rdata), .o_mem_addr(maddr), .o_mem_wdata(mwdata), .o_mem_we(mwe),
        .i_mem_rdata(mrdata), .o_busy(busy)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req0(reqb), .i_we0(1'b0), .i_addr0(addrb), .i_wdata0(32'h0), .o_ack0(ackb),
        .i_req1(1'b0), .i_we1(1'b0), .i_addr1(7'h0), .i_wdata1(32'h0), .o_ack1(ack1b),
        .o_rdata(rdatab), .o_mem_addr(maddrb), .o_mem_wdata(mwdatab), .o_mem_we(mweb),
        .i_mem_rdata(mrdatab), .o_busy(busyb)
    );

    // Memory models: registered read; latency 1 for A, 3 for B
    logic [DW-1:0] memA [0:(1<<AW)-1];
    logic [DW-1:0] memB [0:(1<<AW)-1];
    logic [DW-1:0] pb1, pb2;
    always @(posedge clk) begin
        if (mwe) memA[maddr] <= mwdata;
        mrdata <= memA[maddr];
        pb1    <= memB[maddrb];
        pb2    <= pb1;
        mrdatab <= pb2;
    end

    // Monitors (sampled on negedge, away from the active edge)
    int cyc = 0;
    int we_pulses = 0;
    int both_ack = 0;
    int            ack_port [$];
    int            ack_cyc  [$];
    logic [DW-1:0] ack_data [$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mwe) we_pulses++;
        if (ack0 && ack1) both_ack++;
        if (ack0) begin ack_port.push_back(0); ack_cyc.push_back(cyc); ack_data.push_back(rdata); end
        if (ack1) begin ack_port.push_back(1); ack_cyc.push_back(cyc); ack_data.push_back(rdata); end
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n_ack;

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            memA[i] = 32'hA000_0000 + i;
            memB[i] = 32'hB000_0000 + i;
        end
        memA[5] = 32'hDEAD_BEEF;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        reqb = 0; addrb = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_we", mwe, 0);
        chk("rst_addr", maddr, 0);
        chk("rst_wdata", mwdata, 0);
        chk("rst_rdata", rdata, 0);

        // Single read, port 0, address 5
        req0 = 1; we0 = 0; addr0 = 7'd5;
        tick();
        chk("rd_issue_addr", maddr, 5);
        chk("rd_issue_busy", busy, 1);
        chk("rd_issue_we", mwe, 0);
        tick();
        chk("rd_wait_ack", ack0, 0);
        tick();
        chk("rd_ack0", ack0, 1);
        chk("rd_ack1", ack1, 0);
        chk("rd_data", rdata, 32'hDEAD_BEEF);
        req0 = 0;
        tick();
        chk("rd_after_ack", ack0, 0);
        chk("rd_idle_busy", busy, 0);
        chk("rd_no_we", we_pulses, 0);

        // Single write, port 1, address 7
        req1 = 1; we1 = 1; addr1 = 7'd7; wdata1 = 32'h1234_5678;
        tick();
        chk("wr_we", mwe, 1);
        chk("wr_addr", maddr, 7);
        chk("wr_wdata", mwdata, 32'h1234_5678);
        tick();
        chk("wr_we_off", mwe, 0);
        chk("wr_early_ack", ack1, 0);
        tick();
        chk("wr_ack1", ack1, 1);
        chk("wr_rdata_kept", rdata, 32'hDEAD_BEEF);
        req1 = 0; we1 = 0;
        tick();
        chk("wr_one_pulse", we_pulses, 1);

        // Read back address 7 via port 0
        req0 = 1; addr0 = 7'd7;
        tick(); tick(); tick();
        chk("rb_ack0", ack0, 1);
        chk("rb_data", rdata, 32'h1234_5678);
        req0 = 0;
        tick();

        // Contention from reset: both ports reading continuously
        rst = 1; tick(); rst = 0;
        ack_port.delete(); ack_cyc.delete(); ack_data.delete();
        req0 = 1; we0 = 0; addr0 = 7'd3;
        req1 = 1; we1 = 0; addr1 = 7'd9;
        repeat (16) tick();
        req0 = 0; req1 = 0;
        repeat (4) tick();
        chk("ct_count", ack_port.size(), 4);
        if (ack_port.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ct_port%0d", i), ack_port[i], CPU_PRIO ? 0 : (i % 2));
                chk($sformatf("ct_space%0d", i), ack_cyc[i] - ack_cyc[0], 4 * i);
                chk($sformatf("ct_data%0d", i), ack_data[i],
                    (CPU_PRIO || (i % 2) == 0) ? 32'hA000_0003 : 32'hA000_0009);
            end
        end
        chk("ct_excl", both_ack, 0);

        // Reset mid-transaction; the pointer is first moved to port 1
        req0 = 1; addr0 = 7'd5;
        tick(); tick(); tick();
        req0 = 0;
        tick();
        req0 = 1; addr0 = 7'd4;
        tick(); tick();
        n_ack = ack_port.size();
        rst = 1;
        tick();
        rst = 0; req0 = 0;
        chk("mr_busy", busy, 0);
        chk("mr_ack0", ack0, 0);
        chk("mr_rdata", rdata, 0);
        chk("mr_we", mwe, 0);
        tick(); tick();
        chk("mr_no_ack", ack_port.size(), n_ack);
        req0 = 1; addr0 = 7'd5; req1 = 1; addr1 = 7'd9;
        tick(); tick(); tick();
        chk("mr_ptr_ack0", ack0, 1);
        chk("mr_ptr_ack1", ack1, 0);
        chk("mr_ptr_data", rdata, 32'hDEAD_BEEF);
        req0 = 0; req1 = 0;
        tick(); tick();

        // MEM_LAT = 3 read on DUT B
        reqb = 1; addrb = 7'd11;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("l3_addr%0d", k), maddrb, 11);
            chk($sformatf("l3_noack%0d", k), ackb, 0);
        end
        tick();
        chk("l3_ack", ackb, 1);
        chk("l3_data", rdatab, 32'hB000_000B);
        reqb = 0;
        tick();
        chk("l3_idle", busyb, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single-port on-chip memory between the CPU (port 0) and a program loader/debug master (port 1).
- Sits between the CPU/loader and the memory instance inside soc.
- Serialises accesses, drives the memory address/data/write-enable, captures read data after the memory latency, and returns a one-cycle acknowledge to the winning requester.
- Round-robin arbitration by default.

Parameters:
- ADDR_W, 7, memory word-address width driven to memory i_addr.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles, from address presented to o_data valid (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_req0  in  1  port 0 (CPU) request; held high until o_ack0
- i_we0  in  1  port 0 write (1) / read (0)
- i_addr0  in  ADDR_W  port 0 address
- i_wdata0  in  DATA_W  port 0 write data
- o_ack0  out  1  port 0 transaction complete, one-cycle pulse
- i_req1, i_we1, i_addr1, i_wdata1, o_ack1  same as port 0, for port 1 (loader)
- o_rdata  out  DATA_W  read data, valid in the ack cycle, held until next capture
- o_mem_addr  out  ADDR_W  to memory i_addr
- o_mem_wdata  out  DATA_W  to memory i_data
- o_mem_we  out  1  to memory i_wre
- i_mem_rdata  in  DATA_W  from memory o_data
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, o_ack0=o_ack1=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_rdata=0, o_busy=0, priority pointer=port 0.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Sample i_req0/i_req1. If neither is set, stay in IDLE.
  - If exactly one is set, grant it.
  - If both are set, grant the port named by the priority pointer.
  - On grant: latch the granted port's addr/wdata/we and the port id, then go to ISSUE.
- ISSUE (1 cycle):
  - o_mem_addr and o_mem_wdata hold the latched values.
  - o_mem_we = latched we, for this cycle only.
  - Load the latency counter with MEM_LAT-1, then go to WAIT.
- WAIT:
  - o_mem_addr is held and o_mem_we=0.
  - Count down; at 0, capture i_mem_rdata into o_rdata (reads only; writes leave o_rdata unchanged), then go to DONE.
- DONE (1 cycle):
  - o_ackN=1 for the granted port only.
  - Priority pointer moves to the other port.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle T gives the ack at T+MEM_LAT+2. Peak rate is one transaction per MEM_LAT+3 cycles.
- Requester rules:
  - Request inputs must remain stable from assertion through the ack cycle.
  - A request deasserted before ack is ignored if still in IDLE. Once granted, the transaction completes and acks regardless.
- Ack exclusivity: o_ack0 and o_ack1 are never high together and never high outside DONE.
- Simultaneous requests: strict alternation. With both ports requesting continuously, grants go 0,1,0,1,...
- A port re-requesting in the cycle after its ack competes normally in IDLE.
- Reset mid-transaction: rst has priority over every state. Return to IDLE the same edge, o_mem_we=0, no ack issued, pending transaction lost. A write already issued in ISSUE is not undone.
- Address width: only the low ADDR_W bits are used. No wrap detection; the memory wraps naturally.
- No combinational path from any i_req to any output; all outputs are registered.

Optional Feature:
- Macro: ARB_CPU_PRIO_EN.
- Defined: fixed priority, port 0 always wins simultaneous requests. The priority pointer is removed. Port 1 is served only when i_req0 is low in IDLE; loader starvation is acceptable (the loader is used with the CPU held in reset).
- Undefined: round-robin as above.

Test Plan:
- Single read: memory word 5 preloaded 0xDEADBEEF; i_req0=1, i_we0=0, i_addr0=5 at T -> o_mem_addr=5 at T+1; o_ack0=1 and o_rdata=0xDEADBEEF at T+3 (MEM_LAT=1); o_mem_we never high.
- Single write: i_req1=1, i_we1=1, i_addr1=7, i_wdata1=0x12345678 -> o_mem_we high exactly one cycle with addr 7, o_ack1 two cycles later; a subsequent port 0 read of address 7 returns 0x12345678.
- Contention round-robin: both ports request reads continuously from reset -> ack order 0,1,0,1; acks spaced 4 cycles apart; never both acks in one cycle.
- Fixed priority (ARB_CPU_PRIO_EN): both ports request continuously for 3 transactions -> port 0 acked 3 times, port 1 never; drop i_req0 -> port 1 acked next.
- Reset mid-operation: assert rst during WAIT of a port 0 read -> next cycle o_busy=0, no o_ack0 pulse, o_rdata=0, pointer back to port 0.
- MEM_LAT=3 build: single read -> ack at T+5 with correct data; o_mem_addr stable for all 4 cycles from ISSUE through the end of WAIT.
